// File: rtl/dmaster_packets_to_bytes.sv
// Serialises channelled packet beats into an escaped byte stream with
// channel, SOP and EOP markers, one byte per cycle into a registered output.
//
// phase        | meaning
// -------------+----------------------------------------------------
// PH_START     | beat start; the effective phase is the first one that applies
// PH_CHAN_MARK | emit 0x7C channel marker
// PH_CHAN_ESC  | emit 0x7D before a reserved channel byte
// PH_CHAN_BYTE | emit the channel byte, XORed with 0x20 if reserved
// PH_SOP       | emit 0x7A
// PH_EOP       | emit 0x7B
// PH_DATA_ESC  | emit 0x7D before a reserved data byte
// PH_DATA      | emit the data byte, XORed with 0x20 if reserved; beat consumed
module dmaster_packets_to_bytes #(
   parameter int CHANNEL_WIDTH  = 8,
   parameter bit ENCODE_CHANNEL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data
);

   localparam logic [2:0] PH_START     = 3'd0;
   localparam logic [2:0] PH_CHAN_MARK = 3'd1;
   localparam logic [2:0] PH_CHAN_ESC  = 3'd2;
   localparam logic [2:0] PH_CHAN_BYTE = 3'd3;
   localparam logic [2:0] PH_SOP       = 3'd4;
   localparam logic [2:0] PH_EOP       = 3'd5;
   localparam logic [2:0] PH_DATA_ESC  = 3'd6;
   localparam logic [2:0] PH_DATA      = 3'd7;

   logic [2:0]               phase_q, phase_d;
   logic                     out_valid_q, out_valid_d;
   logic [7:0]               out_data_q, out_data_d;
   logic [CHANNEL_WIDTH-1:0] last_channel_q, last_channel_d;
   logic                     chan_valid_q, chan_valid_d;

   logic [7:0] chan_byte;
   logic       chan_rsvd, data_rsvd, chan_needed, load_en;
   logic [2:0] from_sop, from_eop, from_data, phase_cur, phase_next;
   logic [7:0] enc_byte;

   function automatic logic is_rsvd(input logic [7:0] b);
      return (b >= 8'h7A) && (b <= 8'h7D);
   endfunction

   always_comb begin
      chan_byte   = 8'(in_channel);
      chan_rsvd   = is_rsvd(chan_byte);
      data_rsvd   = is_rsvd(in_data);
      chan_needed = ENCODE_CHANNEL && in_startofpacket &&
                    (!chan_valid_q || (in_channel != last_channel_q));

      from_data = data_rsvd ? PH_DATA_ESC : PH_DATA;
      from_eop  = in_endofpacket ? PH_EOP : from_data;
      from_sop  = in_startofpacket ? PH_SOP : from_eop;
      phase_cur = (phase_q == PH_START) ? (chan_needed ? PH_CHAN_MARK : from_sop) : phase_q;

      enc_byte   = in_data;
      phase_next = PH_START;
      case (phase_cur)
         PH_CHAN_MARK: begin
            enc_byte   = 8'h7C;
            phase_next = chan_rsvd ? PH_CHAN_ESC : PH_CHAN_BYTE;
         end
         PH_CHAN_ESC: begin
            enc_byte   = 8'h7D;
            phase_next = PH_CHAN_BYTE;
         end
         PH_CHAN_BYTE: begin
            enc_byte   = chan_rsvd ? (chan_byte ^ 8'h20) : chan_byte;
            phase_next = from_sop;
         end
         PH_SOP: begin
            enc_byte   = 8'h7A;
            phase_next = from_eop;
         end
         PH_EOP: begin
            enc_byte   = 8'h7B;
            phase_next = from_data;
         end
         PH_DATA_ESC: begin
            enc_byte   = 8'h7D;
            phase_next = PH_DATA;
         end
         PH_DATA: begin
            enc_byte   = data_rsvd ? (in_data ^ 8'h20) : in_data;
            phase_next = PH_START;
         end
         default: begin
            enc_byte   = in_data;
            phase_next = PH_START;
         end
      endcase

      load_en = !out_valid_q || out_ready;
      // Held low in reset so a beat is never consumed by a cycle whose load is discarded.
      in_ready = reset_n && load_en && in_valid && (phase_cur == PH_DATA);

      phase_d        = phase_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      last_channel_d = last_channel_q;
      chan_valid_d   = chan_valid_q;
      if (load_en) begin
         if (in_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_byte;
            phase_d     = phase_next;
            if (phase_cur == PH_CHAN_BYTE) begin
               last_channel_d = in_channel;
               chan_valid_d   = 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_q        <= PH_START;
         out_valid_q    <= 1'b0;
         out_data_q     <= 8'h00;
         last_channel_q <= '0;
         chan_valid_q   <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         last_channel_q <= last_channel_d;
         chan_valid_q   <= chan_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_dmaster_packets_to_bytes.sv
// Directed and randomised-backpressure bench for the packet-to-byte encoder,
// with a second instance built without channel encoding.
module tb_dmaster_packets_to_bytes;

   typedef struct {
      logic [7:0] d;
      logic [7:0] ch;
      bit         s;
      bit         e;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [7:0] in_channel = 8'h00;
   logic       in_sop = 1'b0;
   logic       in_eop = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, in_ready0, out_valid0;
   logic [7:0] out_data, out_data0;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         acc_cnt = 0;
   bit         bp_en = 1'b0;
   logic [7:0] cap_q[$];
   logic [7:0] cap0_q[$];
   bit         hold_chk = 1'b0;
   logic [7:0] held;

   dmaster_packets_to_bytes #(.CHANNEL_WIDTH(8), .ENCODE_CHANNEL(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
      .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
      .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data));

   dmaster_packets_to_bytes #(.CHANNEL_WIDTH(8), .ENCODE_CHANNEL(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_ready(in_ready0), .in_valid(in_valid),
      .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
      .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(out_valid0),
      .out_data(out_data0));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (hold_chk && reset_n) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%02h, need valid=1 data=%02h",
                     out_valid, out_data, held);
         end
      end
      hold_chk = reset_n && out_valid && !out_ready;
      held     = out_data;
      if (out_valid && out_ready) cap_q.push_back(out_data);
      if (out_valid0 && out_ready) cap0_q.push_back(out_data0);
      if (in_valid && in_ready) acc_cnt++;
   end

   task automatic do_reset();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input bit sel0, input logic [7:0] d, input logic [7:0] ch,
                            input bit s, input bit e);
      bit got = 1'b0;
      in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = s; in_eop = e;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (sel0 ? in_ready0 : in_ready) got = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL beat_timeout: beat data=%02h not accepted within 100 cycles", d);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; in_channel = 8'h00; in_sop = 1'b0; in_eop = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_cmp++;
      if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %02h need 00", out_data); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
      in_valid = 1'b0;
      reset_n  = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_packet();
      logic [7:0] exp[$] = '{8'h7C, 8'h00, 8'h7A, 8'h01, 8'h02, 8'h7B, 8'h03};
      cap_q.delete(); acc_cnt = 0;
      send_beat(1'b0, 8'h01, 8'h00, 1'b1, 1'b0);
      send_beat(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
      send_beat(1'b0, 8'h03, 8'h00, 1'b0, 1'b1);
      idle(4);
      n_cmp++;
      if (cap_q.size() != exp.size()) begin
         n_fail++; $display("FAIL basic_len: got %0d bytes need %0d", cap_q.size(), exp.size());
      end else
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp[i]) begin
               n_fail++; $display("FAIL basic_byte%0d: got %02h need %02h", i, cap_q[i], exp[i]);
            end
         end
      n_cmp++;
      if (acc_cnt != 3) begin n_fail++; $display("FAIL basic_in_ready: got %0d pulses need 3", acc_cnt); end
   endtask

   task automatic test_same_channel_single();
      logic [7:0] exp[$] = '{8'h7A, 8'h7B, 8'h55};
      cap_q.delete();
      send_beat(1'b0, 8'h55, 8'h00, 1'b1, 1'b1);
      idle(4);
      n_cmp++;
      if (cap_q.size() != exp.size()) begin
         n_fail++; $display("FAIL single_len: got %0d bytes need %0d", cap_q.size(), exp.size());
      end else
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp[i]) begin
               n_fail++; $display("FAIL single_byte%0d: got %02h need %02h", i, cap_q[i], exp[i]);
            end
         end
   endtask

   task automatic test_reserved();
      logic [7:0] exp[$] = '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h10};
      cap_q.delete();
      send_beat(1'b0, 8'h7A, 8'h7B, 1'b1, 1'b0);
      send_beat(1'b0, 8'h10, 8'h7B, 1'b0, 1'b1);
      idle(4);
      n_cmp++;
      if (cap_q.size() != exp.size()) begin
         n_fail++; $display("FAIL reserved_len: got %0d bytes need %0d", cap_q.size(), exp.size());
      end else
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp[i]) begin
               n_fail++; $display("FAIL reserved_byte%0d: got %02h need %02h", i, cap_q[i], exp[i]);
            end
         end
   endtask

   task automatic test_random_backpressure();
      beat_t      sent[$];
      beat_t      dec[$];
      beat_t      b;
      bit         esc, want_ch, ps, pe;
      logic [7:0] cur_ch, v;
      bit         is_val;
      do_reset();
      cap_q.delete();
      bp_en = 1'b1;
      for (int p = 0; p < 200; p++) begin
         int len = $urandom_range(1, 4);
         logic [7:0] ch = ($urandom_range(0, 3) == 0) ? 8'(8'h7A + $urandom_range(0, 3))
                                                      : 8'($urandom_range(0, 3));
         for (int k = 0; k < len; k++) begin
            b.d  = ($urandom_range(0, 4) == 0) ? 8'(8'h7A + $urandom_range(0, 3))
                                               : 8'($urandom_range(0, 255));
            b.ch = ch; b.s = (k == 0); b.e = (k == len - 1);
            sent.push_back(b);
            send_beat(1'b0, b.d, b.ch, b.s, b.e);
         end
      end
      bp_en = 1'b0;
      idle(10);
      esc = 0; want_ch = 0; ps = 0; pe = 0; cur_ch = 8'h00;
      foreach (cap_q[i]) begin
         is_val = 1'b0; v = cap_q[i];
         if (esc) begin v = cap_q[i] ^ 8'h20; esc = 0; is_val = 1'b1; end
         else if (cap_q[i] == 8'h7D) esc = 1;
         else if (cap_q[i] == 8'h7C) want_ch = 1;
         else if (cap_q[i] == 8'h7A) ps = 1;
         else if (cap_q[i] == 8'h7B) pe = 1;
         else is_val = 1'b1;
         if (is_val) begin
            if (want_ch) begin cur_ch = v; want_ch = 0; end
            else begin
               b.d = v; b.ch = cur_ch; b.s = ps; b.e = pe;
               dec.push_back(b); ps = 0; pe = 0;
            end
         end
      end
      n_cmp++;
      if (dec.size() != sent.size()) begin
         n_fail++; $display("FAIL random_beats: got %0d decoded beats need %0d", dec.size(), sent.size());
      end else
         foreach (sent[i]) begin
            n_cmp++;
            if (dec[i].d !== sent[i].d || dec[i].s !== sent[i].s || dec[i].e !== sent[i].e ||
                (sent[i].s && dec[i].ch !== sent[i].ch)) begin
               n_fail++;
               $display("FAIL random_beat%0d: got d=%02h ch=%02h s=%b e=%b need d=%02h ch=%02h s=%b e=%b",
                        i, dec[i].d, dec[i].ch, dec[i].s, dec[i].e,
                        sent[i].d, sent[i].ch, sent[i].s, sent[i].e);
            end
         end
   endtask

   task automatic test_reset_mid_beat();
      logic [7:0] exp[$] = '{8'h7C, 8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h01};
      do_reset();
      cap_q.delete();
      in_valid = 1'b1; in_data = 8'h01; in_channel = 8'h00; in_sop = 1'b1; in_eop = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h7C) begin
         n_fail++; $display("FAIL midreset_first: got valid=%b data=%02h need 1/7C", out_valid, out_data);
      end
      reset_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b need 0", out_valid); end
      reset_n = 1'b1;
      send_beat(1'b0, 8'h01, 8'h00, 1'b1, 1'b1);
      idle(4);
      n_cmp++;
      if (cap_q.size() != exp.size()) begin
         n_fail++; $display("FAIL midreset_len: got %0d bytes need %0d", cap_q.size(), exp.size());
      end else
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp[i]) begin
               n_fail++; $display("FAIL midreset_byte%0d: got %02h need %02h", i, cap_q[i], exp[i]);
            end
         end
   endtask

   task automatic test_no_channel_encode();
      logic [7:0] exp[$] = '{8'h7A, 8'h7B, 8'h7D, 8'h5C};
      do_reset();
      cap0_q.delete();
      send_beat(1'b1, 8'h7C, 8'h05, 1'b1, 1'b1);
      idle(4);
      n_cmp++;
      if (cap0_q.size() != exp.size()) begin
         n_fail++; $display("FAIL nochan_len: got %0d bytes need %0d", cap0_q.size(), exp.size());
      end else
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (cap0_q[i] !== exp[i]) begin
               n_fail++; $display("FAIL nochan_byte%0d: got %02h need %02h", i, cap0_q[i], exp[i]);
            end
         end
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_same_channel_single();
      test_reserved();
      test_random_backpressure();
      test_reset_mid_beat();
      test_no_channel_encode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
